// File: rtl/fir_xifu_result_sched.sv
// In-order commit scheduler for the FIR XIFU result channel.
// Tracks offloaded instructions and returns their results on the XIF result port in issue order.
module fir_xifu_result_sched #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [ID_W-1:0]            issue_id_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       issue_we_i,
  input  logic                       issue_mem_i,
  input  logic                       ex_valid_i,
  input  logic [ID_W-1:0]            ex_id_i,
  input  logic [31:0]                ex_data_i,
  input  logic                       mem_valid_i,
  input  logic [ID_W-1:0]            mem_id_i,
  input  logic [31:0]                mem_data_i,
  input  logic                       kill_valid_i,
  input  logic [ID_W-1:0]            kill_id_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_W-1:0]            result_id_o,
  output logic [31:0]                result_data_o,
  output logic [4:0]                 result_rd_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] we_q;
  logic [DEPTH-1:0] src_q;
  logic [DEPTH-1:0] done_q;
  logic [DEPTH-1:0] killed_q;
  logic [ID_W-1:0]  id_q   [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic             err_q;

  logic [DEPTH-1:0] ex_hit;
  logic [DEPTH-1:0] mem_hit;
  logic [DEPTH-1:0] kill_hit;
  logic             dup;
  logic             push;
  logic             pop;
  logic             head_valid;
  logic             err_d;

  // Matching only looks at registered entries, so a same-cycle push is never a target.
  always_comb begin
    ex_hit   = '0;
    mem_hit  = '0;
    kill_hit = '0;
    dup      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ex_hit[i]   = ex_valid_i & valid_q[i] & ~done_q[i] & ~src_q[i] & (id_q[i] == ex_id_i);
      mem_hit[i]  = mem_valid_i & valid_q[i] & ~done_q[i] & src_q[i] & (id_q[i] == mem_id_i);
      kill_hit[i] = kill_valid_i & valid_q[i] & (id_q[i] == kill_id_i);
      if (valid_q[i] && (id_q[i] == issue_id_i)) begin
        dup = 1'b1;
      end
    end
  end

  assign issue_ready_o = (count_q < CW'(DEPTH));
  assign push          = issue_valid_i & issue_ready_o & ~dup;
  assign head_valid    = valid_q[head_q];

  // A killed head leaves silently without waiting for the consumer.
  assign pop = head_valid & (killed_q[head_q] | (done_q[head_q] & result_ready_i));

  assign err_d = (ex_valid_i & ~(|ex_hit))
               | (mem_valid_i & ~(|mem_hit))
               | (issue_valid_i & dup);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      we_q     <= '0;
      src_q    <= '0;
      done_q   <= '0;
      killed_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i]   <= '0;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ex_hit[i]) begin
          done_q[i] <= 1'b1;
          data_q[i] <= ex_data_i;
        end
        if (mem_hit[i]) begin
          done_q[i] <= 1'b1;
          data_q[i] <= mem_data_i;
        end
        if (kill_hit[i]) begin
          killed_q[i] <= 1'b1;
        end
      end

      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end

      // Push can't alias the head slot: full blocks push, and empty has nothing to pop.
      if (push) begin
        valid_q[tail_q]  <= 1'b1;
        id_q[tail_q]     <= issue_id_i;
        rd_q[tail_q]     <= issue_rd_i;
        we_q[tail_q]     <= issue_we_i;
        src_q[tail_q]    <= issue_mem_i;
        done_q[tail_q]   <= 1'b0;
        killed_q[tail_q] <= 1'b0;
        data_q[tail_q]   <= '0;
        tail_q           <= tail_q + 1'b1;
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      err_q <= err_d;
    end
  end

  assign result_valid_o = head_valid & done_q[head_q] & ~killed_q[head_q];
  assign result_id_o    = id_q[head_q];
  assign result_data_o  = data_q[head_q];
  assign result_rd_o    = rd_q[head_q];
  assign result_we_o    = we_q[head_q];
  assign count_o        = count_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_fir_xifu_result_sched.sv
// Scoreboard bench for fir_xifu_result_sched: directed issue/complete/kill sequences,
// expected results queued at issue time and checked by an independent result monitor.
module tb_fir_xifu_result_sched;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [3:0]  issue_id_i = '0;
  logic [4:0]  issue_rd_i = '0;
  logic        issue_we_i = 1'b0;
  logic        issue_mem_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [3:0]  ex_id_i = '0;
  logic [31:0] ex_data_i = '0;
  logic        mem_valid_i = 1'b0;
  logic [3:0]  mem_id_i = '0;
  logic [31:0] mem_data_i = '0;
  logic        kill_valid_i = 1'b0;
  logic [3:0]  kill_id_i = '0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [2:0]  count_o;
  logic        err_o;

  fir_xifu_result_sched #(.DEPTH(4), .ID_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_id_i(issue_id_i), .issue_rd_i(issue_rd_i),
    .issue_we_i(issue_we_i), .issue_mem_i(issue_mem_i),
    .ex_valid_i(ex_valid_i), .ex_id_i(ex_id_i), .ex_data_i(ex_data_i),
    .mem_valid_i(mem_valid_i), .mem_id_i(mem_id_i), .mem_data_i(mem_data_i),
    .kill_valid_i(kill_valid_i), .kill_id_i(kill_id_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } res_t;

  res_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_res(input logic [3:0] id, input logic [31:0] data,
                            input logic [4:0] rd, input logic we);
    res_t r;
    r.id = id; r.data = data; r.rd = rd; r.we = we;
    sb.push_back(r);
  endtask

  // Monitor: every accepted result must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst_i && result_valid_o && result_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_id", {28'd0, result_id_o}, 32'hFFFF_FFFF);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("res_id", {28'd0, result_id_o}, {28'd0, e.id});
        chk("res_data", result_data_o, e.data);
        chk("res_rd", {27'd0, result_rd_o}, {27'd0, e.rd});
        chk("res_we", {31'd0, result_we_o}, {31'd0, e.we});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] id, input logic [4:0] rd, input logic we, input logic mem);
    issue_valid_i = 1'b1; issue_id_i = id; issue_rd_i = rd; issue_we_i = we; issue_mem_i = mem;
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic ex(input logic [3:0] id, input logic [31:0] d);
    ex_valid_i = 1'b1; ex_id_i = id; ex_data_i = d;
    tick();
    ex_valid_i = 1'b0;
  endtask

  task automatic mem(input logic [3:0] id, input logic [31:0] d);
    mem_valid_i = 1'b1; mem_id_i = id; mem_data_i = d;
    tick();
    mem_valid_i = 1'b0;
  endtask

  task automatic kill(input logic [3:0] id);
    kill_valid_i = 1'b1; kill_id_i = id;
    tick();
    kill_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk({nm, "_drain_left"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_count", {29'd0, count_o}, 0);
    chk("rst_ready", {31'd0, issue_ready_o}, 1);
    chk("rst_valid", {31'd0, result_valid_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);

    // 1: mem result then compute result, in order
    result_ready_i = 1'b1;
    issue(4'd1, 5'd5, 1'b1, 1'b1);
    issue(4'd2, 5'd7, 1'b1, 1'b0);
    expect_res(4'd1, 32'h1004, 5'd5, 1'b1);
    mem(4'd1, 32'h1004);
    chk("t1_latency_valid", {31'd0, result_valid_o}, 1);
    chk("t1_latency_id", {28'd0, result_id_o}, 1);
    expect_res(4'd2, 32'hABCD, 5'd7, 1'b1);
    ex(4'd2, 32'hABCD);
    wait_drain("t1");

    // 2: out-of-order completion is reordered
    expect_res(4'd1, 32'h11, 5'd3, 1'b1);
    expect_res(4'd2, 32'h22, 5'd4, 1'b0);
    issue(4'd1, 5'd3, 1'b1, 1'b0);
    issue(4'd2, 5'd4, 1'b0, 1'b1);
    mem(4'd2, 32'h22);
    chk("t2_hold_valid", {31'd0, result_valid_o}, 0);
    tick();
    chk("t2_hold_valid2", {31'd0, result_valid_o}, 0);
    ex(4'd1, 32'h11);
    chk("t2_first_valid", {31'd0, result_valid_o}, 1);
    chk("t2_first_id", {28'd0, result_id_o}, 1);
    tick();
    chk("t2_second_valid", {31'd0, result_valid_o}, 1);
    chk("t2_second_id", {28'd0, result_id_o}, 2);
    wait_drain("t2");

    // 3: fill, full, pop, wrap
    result_ready_i = 1'b0;
    for (int i = 4; i < 8; i++) issue(4'(i), 5'(i), 1'b1, 1'b0);
    chk("t3_full_count", {29'd0, count_o}, 4);
    chk("t3_full_ready", {31'd0, issue_ready_o}, 0);
    for (int i = 4; i < 8; i++) begin
      expect_res(4'(i), 32'h40 + 32'(i), 5'(i), 1'b1);
      ex(4'(i), 32'h40 + 32'(i));
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    chk("t3_after_pop_count", {29'd0, count_o}, 3);
    chk("t3_after_pop_ready", {31'd0, issue_ready_o}, 1);
    result_ready_i = 1'b1;
    wait_drain("t3a");
    for (int i = 12; i < 16; i++) issue(4'(i), 5'(i + 8), 1'b0, 1'b1);
    chk("t3_wrap_count", {29'd0, count_o}, 4);
    for (int i = 12; i < 16; i++) expect_res(4'(i), 32'h2000 + 32'(i), 5'(i + 8), 1'b0);
    for (int i = 15; i >= 12; i--) mem(4'(i), 32'h2000 + 32'(i));
    wait_drain("t3b");
    chk("t3_empty_count", {29'd0, count_o}, 0);

    // 4: backpressure holds the head stable
    result_ready_i = 1'b0;
    expect_res(4'd1, 32'hBEEF, 5'd9, 1'b1);
    issue(4'd1, 5'd9, 1'b1, 1'b0);
    ex(4'd1, 32'hBEEF);
    for (int k = 0; k < 3; k++) begin
      chk("t4_bp_valid", {31'd0, result_valid_o}, 1);
      chk("t4_bp_id", {28'd0, result_id_o}, 1);
      chk("t4_bp_data", result_data_o, 32'hBEEF);
      tick();
    end
    result_ready_i = 1'b1;
    wait_drain("t4");

    // 5: kill an undone head, then a done head
    expect_res(4'd4, 32'h44, 5'd4, 1'b1);
    issue(4'd3, 5'd3, 1'b1, 1'b0);
    issue(4'd4, 5'd4, 1'b1, 1'b0);
    ex(4'd4, 32'h44);
    chk("t5_blocked_valid", {31'd0, result_valid_o}, 0);
    kill(4'd3);
    chk("t5_killed_valid", {31'd0, result_valid_o}, 0);
    tick();
    chk("t5_next_valid", {31'd0, result_valid_o}, 1);
    chk("t5_next_id", {28'd0, result_id_o}, 4);
    wait_drain("t5a");
    result_ready_i = 1'b0;
    issue(4'd3, 5'd3, 1'b1, 1'b0);
    ex(4'd3, 32'h33);
    chk("t5_done_valid", {31'd0, result_valid_o}, 1);
    kill(4'd3);
    chk("t5_done_killed_valid", {31'd0, result_valid_o}, 0);
    tick();
    chk("t5_silent_pop_count", {29'd0, count_o}, 0);
    kill(4'd9);
    chk("t5_unmatched_kill_err", {31'd0, err_o}, 0);

    // 6: protocol errors and reset mid-operation
    issue(4'd2, 5'd2, 1'b1, 1'b0);
    ex(4'd9, 32'h99);
    chk("t6_unknown_err", {31'd0, err_o}, 1);
    chk("t6_unknown_count", {29'd0, count_o}, 1);
    tick();
    chk("t6_err_pulse_end", {31'd0, err_o}, 0);
    mem(4'd2, 32'h55);
    chk("t6_src_mismatch_err", {31'd0, err_o}, 1);
    issue(4'd2, 5'd2, 1'b1, 1'b0);
    chk("t6_dup_err", {31'd0, err_o}, 1);
    chk("t6_dup_count", {29'd0, count_o}, 1);
    issue_valid_i = 1'b1; issue_id_i = 4'd6; issue_rd_i = 5'd6; issue_we_i = 1'b1; issue_mem_i = 1'b0;
    ex_valid_i = 1'b1; ex_id_i = 4'd6; ex_data_i = 32'h66;
    tick();
    issue_valid_i = 1'b0; ex_valid_i = 1'b0;
    chk("t6_same_cycle_err", {31'd0, err_o}, 1);
    chk("t6_same_cycle_count", {29'd0, count_o}, 2);
    issue(4'd7, 5'd7, 1'b1, 1'b0);
    ex(4'd2, 32'h22);
    chk("t6_pre_rst_valid", {31'd0, result_valid_o}, 1);
    chk("t6_pre_rst_count", {29'd0, count_o}, 3);
    rst_i = 1'b1;
    ex_valid_i = 1'b1; ex_id_i = 4'd9; ex_data_i = 32'h1;
    tick();
    ex_valid_i = 1'b0;
    rst_i = 1'b0;
    chk("t6_rst_count", {29'd0, count_o}, 0);
    chk("t6_rst_valid", {31'd0, result_valid_o}, 0);
    chk("t6_rst_ready", {31'd0, issue_ready_o}, 1);
    chk("t6_rst_err", {31'd0, err_o}, 0);
    tick();
    chk("t6_post_rst_err", {31'd0, err_o}, 0);
    chk("sb_empty_at_end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
